// File: rtl/rx_100101_pkg.sv
// -----------------------------------------------------------------------------
// rx_100101_pkg
// Shared definitions for the 100101 mirrored-frame receiver and the matching
// pattern generator benches.
//   WORD_W          : width of the recovered data word
//   FRAME_LEN       : serial frame length (forward half + mirrored half)
//   IDX_W           : width of the in-frame bit index
//   PATTERN_DEFAULT : word that raises the receiver's hit pulse by default
//   state_e         : receiver FSM states
//   mirror_ref()    : forward-register bit expected at a given reverse index
// -----------------------------------------------------------------------------
package rx_100101_pkg;

  localparam int WORD_W    = 6;
  localparam int FRAME_LEN = 12;
  localparam int IDX_W     = 4;

  localparam logic [WORD_W-1:0] PATTERN_DEFAULT = 6'b100101;

  // Last forward index (w[0]) and last frame index (w[5] of the mirror).
  localparam logic [IDX_W-1:0] IDX_LAST_FWD = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2
  } state_e;

  // The mirrored half carries w[0] first, so reverse index i compares
  // against forward bit (i - 6). Out-of-range indices return 0.
  function automatic logic mirror_ref(input logic [WORD_W-1:0] fwd,
                                      input logic [IDX_W-1:0]  idx);
    logic bit_s;
    case (idx)
      4'd6:    bit_s = fwd[0];
      4'd7:    bit_s = fwd[1];
      4'd8:    bit_s = fwd[2];
      4'd9:    bit_s = fwd[3];
      4'd10:   bit_s = fwd[4];
      4'd11:   bit_s = fwd[5];
      default: bit_s = 1'b0;
    endcase
    return bit_s;
  endfunction

endpackage

// File: rtl/rx_100101_sat_cnt.sv
// -----------------------------------------------------------------------------
// sat_cnt
// Parameterised saturating up-counter. Counts inc pulses and sticks at
// all-ones instead of wrapping.
//   clk : rising-edge clock
//   clr : asynchronous active-high reset, clears the count
//   inc : count enable, one step per cycle it is high
//   q   : registered count value
// -----------------------------------------------------------------------------
module sat_cnt
  import rx_100101_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step on inc unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/rx_100101.sv
// -----------------------------------------------------------------------------
// rx_100101
// Serial receiver/checker for the 12-bit mirrored frame
//   w[5] w[4] w[3] w[2] w[1] w[0] w[0] w[1] w[2] w[3] w[4] w[5]
// Locks on start, deserialises the forward half MSB-first, checks that the
// second half mirrors it, and reports the recovered word once per frame.
// Frames repeat back-to-back without a new start.
//   PATTERN : word that raises hit
//   CNT_W   : width of hit_cnt
//   clk     : rising-edge clock
//   clr     : asynchronous active-high reset
//   start   : alignment strobe, high in the cycle din carries w[5]
//   din     : serial data
//   word    : last recovered word (holds between frames)
//   valid   : one-cycle pulse per completed frame
//   err     : mirror mismatch of the last completed frame (holds)
//   hit     : one-cycle pulse with valid for an error-free PATTERN frame
//   hit_cnt : saturating count of hit pulses
// -----------------------------------------------------------------------------
module rx_100101
  import rx_100101_pkg::*;
#(
  parameter logic [WORD_W-1:0] PATTERN = PATTERN_DEFAULT,
  parameter int                CNT_W   = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              din,
  output logic [WORD_W-1:0] word,
  output logic              valid,
  output logic              err,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_cnt
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [WORD_W-1:0]  fwd_q,   fwd_d;
  logic               mm_q,    mm_d;
  logic [WORD_W-1:0]  word_q,  word_d;
  logic               valid_q, valid_d;
  logic               err_q,   err_d;
  logic               hit_q,   hit_d;

  // Mismatch including the current reverse-half compare.
  logic               mm_next_s;
  // Forward register with the current din shifted in as the newest bit.
  logic [WORD_W-1:0]  fwd_shift_s;

  assign fwd_shift_s = {fwd_q[WORD_W-2:0], din};

  // Next-state, datapath and output decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    fwd_d     = fwd_q;
    mm_d      = mm_q;
    word_d    = word_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    hit_d     = 1'b0;
    mm_next_s = mm_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // din is w[5] of a fresh frame.
          fwd_d   = fwd_shift_s;
          idx_d   = 4'd1;
          mm_d    = 1'b0;
          state_d = FWD;
        end else begin
          state_d = IDLE;
        end
      end

      FWD: begin
        if (start) begin
          // Resync: drop whatever was collected and restart at w[5].
          fwd_d   = fwd_shift_s;
          idx_d   = 4'd1;
          mm_d    = 1'b0;
          state_d = FWD;
        end else if (idx_q == IDX_LAST_FWD) begin
          fwd_d   = fwd_shift_s;
          idx_d   = idx_q + 4'd1;
          state_d = REV;
        end else begin
          fwd_d   = fwd_shift_s;
          idx_d   = idx_q + 4'd1;
          state_d = FWD;
        end
      end

      REV: begin
        mm_next_s = mm_q | (din ^ mirror_ref(fwd_q, idx_q));
        if (idx_q == IDX_LAST) begin
          // Frame completes even if start arrives on this same edge.
          word_d  = fwd_q;
          valid_d = 1'b1;
          err_d   = mm_next_s;
          hit_d   = (!mm_next_s) && (fwd_q == PATTERN);
          mm_d    = 1'b0;
          state_d = FWD;
          if (start) begin
            // The current din doubles as w[5] of the next frame.
            fwd_d = fwd_shift_s;
            idx_d = 4'd1;
          end else begin
            idx_d = 4'd0;
          end
        end else if (start) begin
          fwd_d   = fwd_shift_s;
          idx_d   = 4'd1;
          mm_d    = 1'b0;
          state_d = FWD;
        end else begin
          mm_d    = mm_next_s;
          idx_d   = idx_q + 4'd1;
          state_d = REV;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a clean idle.
        state_d = IDLE;
        idx_d   = 4'd0;
        mm_d    = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      fwd_q   <= 6'd0;
      mm_q    <= 1'b0;
      word_q  <= 6'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fwd_q   <= fwd_d;
      mm_q    <= mm_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
    end
  end

  // Counter steps on the same edge that raises hit, so hit_cnt already
  // includes the current frame while hit is high.
  sat_cnt #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk (clk),
    .clr (clr),
    .inc (hit_d),
    .q   (hit_cnt)
  );

  assign word  = word_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign hit   = hit_q;

endmodule

// File: tb/tb_rx_100101.sv
module tb_rx_100101;

  logic       clk;
  logic       clr;
  logic       start;
  logic       din;

  logic [5:0] word;
  logic       valid;
  logic       err;
  logic       hit;
  logic [7:0] hit_cnt;

  logic [5:0] word2;
  logic       valid2;
  logic       err2;
  logic       hit2;
  logic [1:0] hit_cnt2;

  int n_checks;
  int n_fail;

  rx_100101 #(
    .PATTERN (6'b100101),
    .CNT_W   (8)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .din     (din),
    .word    (word),
    .valid   (valid),
    .err     (err),
    .hit     (hit),
    .hit_cnt (hit_cnt)
  );

  // Narrow counter copy for saturation.
  rx_100101 #(
    .PATTERN (6'b100101),
    .CNT_W   (2)
  ) dut2 (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .din     (din),
    .word    (word2),
    .valid   (valid2),
    .err     (err2),
    .hit     (hit2),
    .hit_cnt (hit_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] fwd;     // forward word w[5:0]
    logic [5:0] rev;     // mirrored half as sent, first-sent bit in [5]
    logic       st;      // start on the first bit
    logic       e_hit;
    logic       e_err;
    logic [5:0] e_word;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one full 12-bit frame; valid/hit must stay low until the last bit.
  task automatic send_frame(input logic [5:0] f, input logic [5:0] r, input logic st);
    for (int k = 0; k < 12; k++) begin
      if (k < 6) din = f[5-k];
      else       din = r[11-k];
      start = (k == 0) ? st : 1'b0;
      tick();
      if (k < 11) begin
        check("valid_mid", {31'd0, valid}, 32'd0);
        check("hit_mid",   {31'd0, hit},   32'd0);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr   = 1'b1;
    start = 1'b0;
    din   = 1'b0;

    //                 fwd        rev        st    hit   err   word       cnt
    tbl[0] = '{6'b100101, 6'b101001, 1'b1, 1'b1, 1'b0, 6'b100101, 8'd1};
    tbl[1] = '{6'b100101, 6'b101001, 1'b0, 1'b1, 1'b0, 6'b100101, 8'd2};
    tbl[2] = '{6'b100101, 6'b101001, 1'b0, 1'b1, 1'b0, 6'b100101, 8'd3};
    tbl[3] = '{6'b011010, 6'b010110, 1'b0, 1'b0, 1'b0, 6'b011010, 8'd3};
    tbl[4] = '{6'b100101, 6'b101000, 1'b0, 1'b0, 1'b1, 6'b100101, 8'd3};
    tbl[5] = '{6'b100101, 6'b101001, 1'b0, 1'b1, 1'b0, 6'b100101, 8'd4};
    tbl[6] = '{6'b111111, 6'b111111, 1'b0, 1'b0, 1'b0, 6'b111111, 8'd4};
    tbl[7] = '{6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 6'b000000, 8'd4};

    // Reset held: random activity must not disturb outputs.
    for (int i = 0; i < 6; i++) begin
      din   = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      tick();
      check("rst_word",  {26'd0, word},    32'd0);
      check("rst_valid", {31'd0, valid},   32'd0);
      check("rst_err",   {31'd0, err},     32'd0);
      check("rst_hit",   {31'd0, hit},     32'd0);
      check("rst_cnt",   {24'd0, hit_cnt}, 32'd0);
    end
    clr   = 1'b0;
    start = 1'b0;
    // Idle without start: no frame may complete.
    for (int i = 0; i < 14; i++) begin
      din = 1'($urandom_range(0, 1));
      tick();
      check("idle_valid", {31'd0, valid}, 32'd0);
    end

    // Table-driven frames, back-to-back after one start.
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].fwd, tbl[i].rev, tbl[i].st);
      check("tbl_valid", {31'd0, valid},   32'd1);
      check("tbl_hit",   {31'd0, hit},     {31'd0, tbl[i].e_hit});
      check("tbl_err",   {31'd0, err},     {31'd0, tbl[i].e_err});
      check("tbl_word",  {26'd0, word},    {26'd0, tbl[i].e_word});
      check("tbl_cnt",   {24'd0, hit_cnt}, {24'd0, tbl[i].e_cnt});
      check("tbl_cnt2",  {30'd0, hit_cnt2},
            (tbl[i].e_cnt > 8'd3) ? 32'd3 : {24'd0, tbl[i].e_cnt});
    end
    // Pulses last a single cycle; word/err hold.
    din = 1'b0;
    tick();
    check("pulse_valid", {31'd0, valid}, 32'd0);
    check("hold_word",   {26'd0, word},  32'd0);

    // Resync at index 7: partial frame with a mirror error, then a new start.
    send_frame(6'b100101, 6'b101001, 1'b1);
    for (int k = 0; k < 7; k++) begin
      din   = (k == 6) ? 1'b0 : ((k == 0 || k == 3 || k == 5) ? 1'b1 : 1'b0);
      start = (k == 0);
      tick();
      check("rs_valid_old", {31'd0, valid}, 32'd0);
    end
    send_frame(6'b011010, 6'b010110, 1'b1);
    check("rs_valid", {31'd0, valid}, 32'd1);
    check("rs_word",  {26'd0, word},  32'h1a);
    check("rs_err",   {31'd0, err},   32'd0);
    check("rs_hit",   {31'd0, hit},   32'd0);

    // clr at index 4 aborts the frame.
    for (int k = 0; k < 4; k++) begin
      din   = (k == 0 || k == 3) ? 1'b1 : 1'b0;
      start = (k == 0);
      tick();
    end
    start = 1'b0;
    clr   = 1'b1;
    #1;
    check("clr_word",  {26'd0, word},     32'd0);
    check("clr_valid", {31'd0, valid},    32'd0);
    check("clr_err",   {31'd0, err},      32'd0);
    check("clr_hit",   {31'd0, hit},      32'd0);
    check("clr_cnt",   {24'd0, hit_cnt},  32'd0);
    check("clr_cnt2",  {30'd0, hit_cnt2}, 32'd0);
    tick();
    clr = 1'b0;
    for (int k = 0; k < 14; k++) begin
      din = (k % 3 == 0) ? 1'b1 : 1'b0;
      tick();
      check("postclr_valid", {31'd0, valid}, 32'd0);
    end
    check("postclr_word", {26'd0, word}, 32'd0);

    // Saturation of the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      send_frame(6'b100101, 6'b101001, (i == 0));
      check("sat_hit",  {31'd0, hit2},     32'd1);
      check("sat_cnt2", {30'd0, hit_cnt2}, (i >= 2) ? 32'd3 : 32'(i + 1));
      check("sat_cnt",  {24'd0, hit_cnt},  32'(i + 1));
    end

    // start on the completion edge: frame reports and din becomes next w[5].
    for (int k = 0; k < 12; k++) begin
      if (k < 6) din = (k == 0 || k == 3 || k == 5) ? 1'b1 : 1'b0;
      else       din = (k == 6 || k == 8 || k == 11) ? 1'b1 : 1'b0;
      start = (k == 11);
      tick();
    end
    start = 1'b0;
    check("ce_valid", {31'd0, valid}, 32'd1);
    check("ce_hit",   {31'd0, hit},   32'd1);
    // Remaining 11 bits of 100101 / 101001 starting at w[4].
    for (int k = 1; k < 12; k++) begin
      if (k < 6) din = (k == 3 || k == 5) ? 1'b1 : 1'b0;
      else       din = (k == 6 || k == 8 || k == 11) ? 1'b1 : 1'b0;
      tick();
      if (k < 11) check("ce_mid", {31'd0, valid}, 32'd0);
    end
    check("ce_next_valid", {31'd0, valid},   32'd1);
    check("ce_next_hit",   {31'd0, hit},     32'd1);
    check("ce_next_cnt",   {24'd0, hit_cnt}, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
